// File: rtl/imem_boot_loader_if.sv
// Byte-stream, core-handoff and instruction-memory signals of the boot loader.
// The master side is the byte source plus core; the slave side is the loader.
interface imem_boot_loader_if;
    logic        start;
    logic [15:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] pc;
    logic [31:0] imem_A;
    logic [31:0] imem_WD;
    logic        imem_WE;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, word_count, byte_valid, byte_data, pc,
        input  byte_ready, imem_A, imem_WD, imem_WE, core_rst_n, busy, done, error
    );

    modport slave (
        input  start, word_count, byte_valid, byte_data, pc,
        output byte_ready, imem_A, imem_WD, imem_WE, core_rst_n, busy, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Packs a little-endian byte stream into 32-bit words, writes them to instruction
// memory, then hands the address port to the core PC and releases core reset.
module imem_boot_loader #(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input logic              clk,
    input logic              rst_n,
    imem_boot_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RECV, WRITE, RUN, ERROR} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] widx;
    logic [1:0]  bidx;
    logic [31:0] wbuf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            widx  <= '0;
            bidx  <= '0;
            wbuf  <= '0;
        end else begin
            case (state)
                IDLE, RUN, ERROR: begin
                    if (bus.start) begin
                        if (bus.word_count == 16'd0) begin
                            state <= RUN;
                        end else if (32'(bus.word_count) > DEPTH_WORDS) begin
                            state <= ERROR;
                        end else begin
                            cnt   <= bus.word_count;
                            widx  <= '0;
                            bidx  <= '0;
                            state <= RECV;
                        end
                    end
                end
                RECV: begin
                    // First byte of each word lands in the low lane.
                    if (bus.byte_valid) begin
                        wbuf[{bidx, 3'b000} +: 8] <= bus.byte_data;
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) state <= WRITE;
                    end
                end
                WRITE: begin
                    widx  <= widx + 16'd1;
                    state <= (widx + 16'd1 == cnt) ? RUN : RECV;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address mux is the only non-Moore output: the core's PC passes straight through.
    assign bus.imem_A     = (state == RUN) ? bus.pc : {14'd0, widx, 2'b00};
    assign bus.imem_WD    = wbuf;
    assign bus.imem_WE    = (state == WRITE);
    assign bus.byte_ready = (state == RECV);
    assign bus.busy       = (state == RECV) || (state == WRITE);
    assign bus.done       = (state == RUN);
    assign bus.core_rst_n = (state == RUN);
    assign bus.error      = (state == ERROR);
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scenario bench for imem_boot_loader: expected memory writes are queued as the
// stream is driven and popped by a write monitor.
module tb_imem_boot_loader;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    imem_boot_loader_if bus();

    imem_boot_loader #(.DEPTH_WORDS(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int t0 = 0;
    wr_t exp_q[$];
    wr_t e;
    logic [31:0] mem [0:63];

    always @(posedge clk) cyc_cnt++;

    // Write monitor + memory model
    always @(negedge clk) begin
        if (bus.imem_WE === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%h data=%h expected none", bus.imem_A, bus.imem_WD);
            end else begin
                e = exp_q.pop_front();
                if (bus.imem_A !== e.a || bus.imem_WD !== e.d) begin
                    bad++;
                    $display("FAIL write addr=%h data=%h expected addr=%h data=%h",
                             bus.imem_A, bus.imem_WD, e.a, e.d);
                end
            end
            mem[bus.imem_A[7:2]] = bus.imem_WD;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        bus.start = 1'b1;
        bus.word_count = n;
        cyc();
        bus.start = 1'b0;
        t0 = cyc_cnt;
    endtask

    // Streams bytes, optionally stalling before index stall_at; reports bytes
    // accepted and stall cycles where byte_ready dropped.
    task automatic stream(input bq_t b, input int stall_at, input int stall_len,
                          output int acc, output int ready_lost);
        int st = 0;
        int g = 0;
        logic take;
        acc = 0;
        ready_lost = 0;
        while (acc < b.size() && g < 200) begin
            if (acc == stall_at && st < stall_len) begin
                bus.byte_valid = 1'b0;
                if (bus.byte_ready !== 1'b1) ready_lost++;
                st++;
            end else begin
                bus.byte_valid = 1'b1;
                bus.byte_data = b[acc];
            end
            take = bus.byte_valid && bus.byte_ready;
            cyc();
            if (take) acc++;
            g++;
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done(output int k);
        int g = 0;
        while (bus.done !== 1'b1 && g < 200) begin
            cyc();
            g++;
        end
        k = cyc_cnt - t0 + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.byte_ready, bus.imem_WE, bus.imem_WD, bus.imem_A, bus.core_rst_n,
             bus.busy, bus.done, bus.error} !== 70'd0) begin
            bad++;
            $display("FAIL reset_outputs ready=%b we=%b wd=%h a=%h crst=%b busy=%b done=%b err=%b expected all 0",
                     bus.byte_ready, bus.imem_WE, bus.imem_WD, bus.imem_A, bus.core_rst_n,
                     bus.busy, bus.done, bus.error);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        bq_t b;
        int acc, rl, k;
        b = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp_q.push_back('{32'h0, 32'h0050_0013});
        exp_q.push_back('{32'h4, 32'h0010_0093});
        do_start(16'd2);
        total++;
        if (bus.byte_ready !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_recv ready=%b busy=%b expected 1 1", bus.byte_ready, bus.busy);
        end
        stream(b, -1, 0, acc, rl);
        total++;
        if (acc != 8) begin bad++; $display("FAIL basic_bytes got %0d expected 8", acc); end
        wait_done(k);
        total++;
        if (k != 11) begin bad++; $display("FAIL basic_done_latency got %0d expected 11", k); end
        total++;
        if (bus.core_rst_n !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_run crst=%b busy=%b expected 1 0", bus.core_rst_n, bus.busy);
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL basic_pending got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        bq_t b;
        int acc, rl, k;
        b = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp_q.push_back('{32'h0, 32'h0050_0013});
        exp_q.push_back('{32'h4, 32'h0010_0093});
        do_start(16'd2);
        stream(b, 2, 3, acc, rl);
        total++;
        if (rl != 0) begin bad++; $display("FAIL stall_ready dropped=%0d expected 0", rl); end
        wait_done(k);
        total++;
        if (k != 14) begin bad++; $display("FAIL stall_done_latency got %0d expected 14", k); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL stall_pending got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_error();
        bq_t b;
        int acc, rl, k;
        do_start(16'd65);
        total++;
        if (bus.error !== 1'b1 || bus.core_rst_n !== 1'b0 || bus.byte_ready !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL error_state err=%b crst=%b ready=%b done=%b expected 1 0 0 0",
                     bus.error, bus.core_rst_n, bus.byte_ready, bus.done);
        end
        cyc();
        total++;
        if (bus.error !== 1'b1) begin bad++; $display("FAIL error_hold got %b expected 1", bus.error); end
        b = '{8'hB7, 8'h12, 8'h00, 8'h00};
        exp_q.push_back('{32'h0, 32'h0000_12B7});
        do_start(16'd1);
        total++;
        if (bus.error !== 1'b0 || bus.byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL error_clear err=%b ready=%b expected 0 1", bus.error, bus.byte_ready);
        end
        stream(b, -1, 0, acc, rl);
        wait_done(k);
        total++;
        if (k != 6) begin bad++; $display("FAIL error_reload_latency got %0d expected 6", k); end
    endtask

    task automatic test_run_pc();
        bq_t b;
        int acc, rl, k;
        bus.pc = 32'h10;
        #1;
        total++;
        if (bus.imem_A !== 32'h10) begin bad++; $display("FAIL run_pc_a got %h expected 00000010", bus.imem_A); end
        bus.pc = 32'h0000_0ABC;
        #1;
        total++;
        if (bus.imem_A !== 32'h0000_0ABC) begin bad++; $display("FAIL run_pc_b got %h expected 00000abc", bus.imem_A); end
        b = '{8'h78, 8'h56, 8'h34, 8'h12};
        exp_q.push_back('{32'h0, 32'h1234_5678});
        do_start(16'd1);
        total++;
        if (bus.core_rst_n !== 1'b0 || bus.done !== 1'b0 || bus.imem_A !== 32'h0) begin
            bad++;
            $display("FAIL run_restart crst=%b done=%b a=%h expected 0 0 00000000",
                     bus.core_rst_n, bus.done, bus.imem_A);
        end
        stream(b, -1, 0, acc, rl);
        wait_done(k);
        total++;
        if (exp_q.size() != 0 || k != 6) begin
            bad++;
            $display("FAIL run_reload pending=%0d latency=%0d expected 0 6", exp_q.size(), k);
        end
    endtask

    task automatic test_start_in_recv();
        bq_t b1, b2;
        int acc, rl, k;
        b1 = '{8'h11, 8'h22};
        b2 = '{8'h33, 8'h44, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_q.push_back('{32'h0, 32'h4433_2211});
        exp_q.push_back('{32'h4, 32'hD4C3_B2A1});
        do_start(16'd2);
        stream(b1, -1, 0, acc, rl);
        bus.start = 1'b1;
        bus.word_count = 16'd5;
        cyc();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL recv_start_ignored busy=%b ready=%b expected 1 1", bus.busy, bus.byte_ready);
        end
        stream(b2, -1, 0, acc, rl);
        wait_done(k);
        total++;
        if (k != 12 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL recv_start_count latency=%0d pending=%0d expected 12 0", k, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        bq_t b;
        int acc, rl;
        b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02};
        exp_q.push_back('{32'h0, 32'hDEAD_BEEF});
        do_start(16'd4);
        stream(b, -1, 0, acc, rl);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.byte_ready, bus.imem_WE, bus.imem_WD, bus.imem_A, bus.core_rst_n,
             bus.busy, bus.done, bus.error} !== 70'd0) begin
            bad++;
            $display("FAIL midreset_outputs ready=%b we=%b wd=%h a=%h crst=%b busy=%b done=%b err=%b expected all 0",
                     bus.byte_ready, bus.imem_WE, bus.imem_WD, bus.imem_A, bus.core_rst_n,
                     bus.busy, bus.done, bus.error);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data = 8'h55;
        repeat (6) cyc();
        bus.byte_valid = 1'b0;
        total++;
        if (mem[0] !== 32'hDEAD_BEEF || exp_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_mem word0=%h pending=%0d expected deadbeef 0", mem[0], exp_q.size());
        end
        total++;
        if (bus.byte_ready !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle ready=%b busy=%b expected 0 0", bus.byte_ready, bus.busy);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.word_count = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data = '0;
        bus.pc = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_error();
        test_run_pc();
        test_start_in_recv();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller for the single-cycle core's instruction memory. It receives a program as a little-endian byte stream over a valid/ready handshake, packs each 4 bytes into a 32-bit word, and writes the words to consecutive instruction-memory word addresses. While loading, it owns the instruction-memory address port and holds the core in reset. After the last word is written, it hands the address port to the core's PC and releases the core.

## Interface
- DEPTH_WORDS, 64: instruction-memory capacity in 32-bit words.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, RUN and ERROR.
- word_count  in  16  number of words to load; sampled on the cycle `start` is accepted.
- byte_valid  in  1  source has a byte on `byte_data`.
- byte_data  in  8  program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- pc  in  32  core fetch address.
- imem_A  out  32  instruction-memory address.
- imem_WD  out  32  instruction-memory write data.
- imem_WE  out  1  instruction-memory write enable.
- core_rst_n  out  1  active-low reset to the core.
- busy  out  1  a load is in progress.
- done  out  1  program loaded; core running.
- error  out  1  last requested `word_count` exceeded DEPTH_WORDS.

## Operation
The FSM has five states: IDLE, RECV, WRITE, RUN, ERROR. All outputs except the `imem_A` mux are decoded from registered state and counters (Moore).

Internal registers:
- `cnt` (16 b): latched word count.
- `widx` (16 b): word index.
- `bidx` (2 b): byte lane.
- `wbuf` (32 b): word assembly buffer.

Reset (asynchronous, `rst_n` = 0):
- state = IDLE; `cnt`, `widx`, `bidx`, `wbuf` = 0.
- Outputs: `byte_ready` = 0, `imem_WE` = 0, `imem_WD` = 0, `imem_A` = 0, `core_rst_n` = 0, `busy` = 0, `done` = 0, `error` = 0.
- Reset asserted mid-load aborts the load immediately. Words already written remain in memory.

IDLE:
- `start` with `word_count` = 0 → RUN.
- `start` with `word_count` > DEPTH_WORDS → ERROR.
- Otherwise `start` latches `cnt`, clears `widx` and `bidx`, and moves to RECV.

RECV:
- `byte_ready` = 1, `busy` = 1.
- On `byte_valid` && `byte_ready`, write `byte_data` into lane `bidx` of `wbuf`, i.e. `wbuf[8*bidx +: 8]`. The first byte goes to [7:0].
- Then `bidx` += 1. When the accepted byte has `bidx` = 3, `bidx` wraps to 0 and the FSM moves to WRITE.
- No byte is accepted on a cycle where `byte_valid` = 0; state is held.

WRITE (exactly one cycle):
- `imem_WE` = 1, `imem_A` = {`widx`, 2'b00} (zero-extended), `imem_WD` = `wbuf`, `byte_ready` = 0, `busy` = 1.
- Next: `widx` += 1. If `widx`+1 == `cnt` → RUN, else → RECV.

RUN:
- `core_rst_n` = 1, `done` = 1, `imem_WE` = 0, `imem_A` = `pc` (combinational pass-through).
- `start` → re-evaluated exactly as in IDLE. `core_rst_n` drops on the next cycle.

ERROR:
- `error` = 1, `core_rst_n` = 0, `byte_ready` = 0.
- `start` → re-evaluated as in IDLE. `error` clears on leaving ERROR.

Other rules:
- `start` is ignored in RECV and WRITE.
- In IDLE, RECV and ERROR: `imem_A` = {`widx`, 2'b00} and `imem_WE` = 0.
- `imem_WD` holds `wbuf` at all times.
- `widx` arithmetic is 16-bit. It cannot overflow because `cnt` ≤ DEPTH_WORDS.

## Timing
- `start` sampled at edge T → state RECV from T+1; `byte_ready` = 1 from T+1.
- With `byte_valid` held high: 4 byte cycles + 1 WRITE cycle = 5 cycles per word.
- N words with no stall: the last WRITE occupies cycle T+5N; `done` = 1 and `core_rst_n` = 1 from T+5N+1.
- Each `byte_valid` stall cycle adds exactly one cycle.
- `word_count` = 0: `done` = 1 at T+1.
- `word_count` > DEPTH_WORDS: `error` = 1 at T+1.
- The memory write itself is the memory's synchronous write on the edge ending the WRITE cycle.

## Test plan
- Reset, then `start` with `word_count` = 2 and bytes 13,00,50,00,93,00,10,00 streamed continuously → writes 0x00500013 at addr 0 and 0x00100093 at addr 4; `done` and `core_rst_n` rise 11 cycles after `start`.
- Same load with `byte_valid` low for 3 cycles between byte 2 and byte 3 → identical writes; `done` 3 cycles later than the no-stall case; `byte_ready` stays 1 throughout the stall.
- `word_count` = 65 with DEPTH_WORDS = 64 → `error` = 1 next cycle, no `imem_WE` pulse, core stays in reset. A following `start` with `word_count` = 1 clears `error` and loads normally.
- In RUN, drive `pc` = 0x10 → `imem_A` = 0x10 in the same cycle. Then `start` with `word_count` = 1 → `core_rst_n` = 0, `done` = 0 next cycle, and the new word is written at addr 0.
- `start` pulsed during RECV → ignored: `cnt` unchanged, load completes with the original count.
- Assert `rst_n` = 0 after 6 bytes of a 4-word load → all outputs return to reset values immediately. Word 0 remains in memory; no further write occurs.
